// File: rtl/exc_pkg.sv
// Shared types and constants for the exception-entry sequencer.
package exc_pkg;

  localparam int unsigned IP_W   = 8;
  localparam int unsigned EXC_W  = 5;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    SAVE,
    JUMP,
    SERVICE
  } state_e;

  localparam logic [EXC_W-1:0] EXC_INT  = 5'd0;
  localparam logic [EXC_W-1:0] EXC_TRAP = 5'd13;
  localparam logic [EXC_W-1:0] EXC_NONE = 5'd10;

  localparam logic [ADDR_W-1:0] VEC_GEN_DFLT = 32'h0000_0180;
  localparam logic [ADDR_W-1:0] VEC_INT_DFLT = 32'h0000_0200;

endpackage

// File: rtl/prio_enc8.sv
// 8-input fixed-priority encoder: the highest-index request wins.
module prio_enc8 (
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic       valid
);

  // Scan upward so the last (highest) set bit overwrites earlier winners.
  always_comb begin
    gnt   = '0;
    valid = |req;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/exc_sequencer.sv
// Exception-entry sequencer: latches traps/IRQs, handshakes with the CU,
// drives the EPC/Cause update and handler jump, and tracks EXL until ERET.
module exc_sequencer
  import exc_pkg::*;
#(
  parameter int unsigned       N_IRQ   = 6,
  parameter logic [ADDR_W-1:0] VEC_GEN = VEC_GEN_DFLT,
  parameter logic [ADDR_W-1:0] VEC_INT = VEC_INT_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_IRQ-1:0]  irq,
  input  logic              trap,
  input  logic [N_IRQ-1:0]  im,
  input  logic              ie,
  input  logic              iv,
  input  logic [ADDR_W-1:0] pcp4,
  input  logic              cu_ack,
  input  logic              eret,
  output logic              cu_req,
  output logic              epc_we,
  output logic [ADDR_W-1:0] epc_wd,
  output logic [EXC_W-1:0]  cause_exc,
  output logic [IP_W-1:0]   cause_ip,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_vec,
  output logic              exl
);

  state_e              state_q, state_d;
  logic [IP_W-1:0]     ip_q, ip_d;
  logic [IP_W-1:0]     win_q, win_d;
  logic [ADDR_W-1:0]   epc_wd_q, epc_wd_d;
  logic [EXC_W-1:0]    cause_exc_q, cause_exc_d;
  logic [ADDR_W-1:0]   pc_vec_q, pc_vec_d;
  logic                cu_req_q, cu_req_d;
  logic                epc_we_q, epc_we_d;
  logic                pc_load_q, pc_load_d;
  logic                exl_q, exl_d;

  logic [N_IRQ-1:0]    irq_m;
  logic [IP_W-1:0]     ip_set;
  logic [IP_W-1:0]     ip_clr;
  logic [IP_W-1:0]     enc_req;
  logic [IP_W-1:0]     enc_gnt;
  logic                enc_valid;
  logic [IP_W-1:0]     gnt_ip;

  // Encoder favours the top bit; rotate so trap (ip[0]) sits above irq5..irq0.
  assign enc_req = {ip_q[0], ip_q[7:1]};
  assign gnt_ip  = {enc_gnt[6:0], enc_gnt[7]};

  prio_enc8 u_prio (
    .req   (enc_req),
    .gnt   (enc_gnt),
    .valid (enc_valid)
  );

  // Next-state, pending-bit and output-register computation.
  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    epc_wd_d    = epc_wd_q;
    cause_exc_d = cause_exc_q;
    pc_vec_d    = pc_vec_q;
    ip_clr      = '0;

    irq_m  = irq & im & {N_IRQ{ie}};
    ip_set = {6'(irq_m) & {6{~exl_q}}, 1'b0, trap};

    case (state_q)
      IDLE: begin
        if (ip_q != '0) state_d = REQ;
      end
      REQ: begin
        if (cu_ack && enc_valid) begin
          epc_wd_d    = pcp4;
          win_d       = gnt_ip;
          cause_exc_d = gnt_ip[0] ? EXC_TRAP : EXC_INT;
          state_d     = SAVE;
        end
      end
      SAVE: begin
        pc_vec_d = (!win_q[0] && iv) ? VEC_INT : VEC_GEN;
        state_d  = JUMP;
      end
      JUMP: begin
        state_d = SERVICE;
      end
      SERVICE: begin
        if (eret) begin
          ip_clr  = win_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A trap arriving with ERET must survive the clear of the serviced bit.
    ip_d = (ip_q & ~ip_clr) | ip_set;

    if (state_d == IDLE) cause_exc_d = EXC_NONE;

    cu_req_d  = (state_d == REQ);
    epc_we_d  = (state_d == SAVE);
    pc_load_d = (state_d == JUMP);
    exl_d     = (state_d == SERVICE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ip_q        <= '0;
      win_q       <= '0;
      epc_wd_q    <= '0;
      cause_exc_q <= EXC_NONE;
      pc_vec_q    <= '0;
      cu_req_q    <= 1'b0;
      epc_we_q    <= 1'b0;
      pc_load_q   <= 1'b0;
      exl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ip_q        <= ip_d;
      win_q       <= win_d;
      epc_wd_q    <= epc_wd_d;
      cause_exc_q <= cause_exc_d;
      pc_vec_q    <= pc_vec_d;
      cu_req_q    <= cu_req_d;
      epc_we_q    <= epc_we_d;
      pc_load_q   <= pc_load_d;
      exl_q       <= exl_d;
    end
  end

  assign cu_req    = cu_req_q;
  assign epc_we    = epc_we_q;
  assign epc_wd    = epc_wd_q;
  assign cause_exc = cause_exc_q;
  assign cause_ip  = ip_q;
  assign pc_load   = pc_load_q;
  assign pc_vec    = pc_vec_q;
  assign exl       = exl_q;

endmodule
